// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: EX-stage owner of the HI/LO pair. It sequences MT*/MF*,
// the internal multi-cycle multiplier and an external iterative divider
// through a start/annul/ready handshake. {HI,LO} is committed once per
// completed instruction.
module hilo_muldiv_ctrl #(
    parameter int          MUL_STAGES = 2,      // multiply latency, legal 1..4
    parameter logic [63:0] HILO_RST   = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        stall_o,
    output logic [31:0] mf_data_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic        div_annul_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    // EXE_*_OP encodings shared with the decoder
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV_BUSY,
        S_DIV_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, lo_q, hi_d, lo_d;
    logic        hi_we, lo_we;
    logic [2:0]  cnt_q, cnt_d;

    logic [31:0] mul_a_q, mul_b_q;
    logic        mul_sgn_q, mul_ld;
    logic [31:0] div_a_q, div_b_q;
    logic        div_sgn_q, div_ld;

    logic        go;
    logic        op_is_mult;
    logic [63:0] prod_now, prod_lat;

    // Signed and unsigned share one 64x64 multiply: sign-extending to 64 bits
    // gives the correct low 64 bits of a signed product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ae, be;
        ae = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        be = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return ae * be;
    endfunction

    assign go         = valid_i & ~flush_i;
    assign op_is_mult = (op_i == EXE_MULT_OP) || (op_i == EXE_MULTU_OP);
    assign prod_now   = mul64(a_i, b_i, op_i == EXE_MULT_OP);
    assign prod_lat   = mul64(mul_a_q, mul_b_q, mul_sgn_q);

    assign hi_o = hi_q;
    assign lo_o = lo_q;

    // Next-state, HI/LO write enables and divider handshake
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        hi_we        = 1'b0;
        lo_we        = 1'b0;
        mul_ld       = 1'b0;
        div_ld       = 1'b0;
        stall_o      = 1'b0;
        div_start_o  = 1'b0;
        div_signed_o = 1'b0;
        div_annul_o  = 1'b0;
        div_opa_o    = 32'h0;
        div_opb_o    = 32'h0;

        case (state_q)
            S_IDLE, S_DIV_DONE: begin
                // DIV_DONE lasts one cycle so the divider sees start drop
                if (state_q == S_DIV_DONE) state_d = S_IDLE;
                if (go) begin
                    if (op_i == EXE_MTHI_OP) begin
                        hi_we = 1'b1;
                        hi_d  = a_i;
                    end else if (op_i == EXE_MTLO_OP) begin
                        lo_we = 1'b1;
                        lo_d  = a_i;
                    end else if (op_is_mult) begin
                        if (MUL_STAGES == 1) begin
                            hi_we = 1'b1;
                            lo_we = 1'b1;
                            hi_d  = prod_now[63:32];
                            lo_d  = prod_now[31:0];
                        end else begin
                            mul_ld  = 1'b1;
                            cnt_d   = MUL_CNT_INIT;
                            state_d = S_MUL;
                            stall_o = 1'b1;
                        end
                    end else if ((op_i == EXE_DIV_OP) || (op_i == EXE_DIVU_OP)) begin
                        stall_o = 1'b1;
                        if (state_q == S_IDLE) begin
                            div_start_o  = 1'b1;
                            div_signed_o = (op_i == EXE_DIV_OP);
                            div_opa_o    = a_i;
                            div_opb_o    = b_i;
                            div_ld       = 1'b1;
                            state_d      = S_DIV_BUSY;
                        end
                        // from DIV_DONE: hold and issue from IDLE next cycle
                    end
                end
            end
            S_MUL: begin
                if (cnt_q <= 3'd1) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_d    = prod_lat[63:32];
                    lo_d    = prod_lat[31:0];
                    state_d = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            S_DIV_BUSY: begin
                div_start_o  = 1'b1;
                div_signed_o = div_sgn_q;
                div_opa_o    = div_a_q;
                div_opb_o    = div_b_q;
                stall_o      = ~div_ready_i;
                if (div_ready_i) begin
                    hi_we   = 1'b1;
                    lo_we   = 1'b1;
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    state_d = S_DIV_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // flush kills the instruction and anything in flight, including a
        // divider result arriving in the same cycle
        if (flush_i) begin
            hi_we   = 1'b0;
            lo_we   = 1'b0;
            mul_ld  = 1'b0;
            div_ld  = 1'b0;
            stall_o = 1'b0;
            state_d = S_IDLE;
            if (state_q == S_DIV_BUSY) begin
                div_annul_o = 1'b1;
                div_start_o = 1'b0;
            end
        end

        // keep every control output quiet while reset is held
        if (rst) begin
            stall_o      = 1'b0;
            div_start_o  = 1'b0;
            div_signed_o = 1'b0;
            div_annul_o  = 1'b0;
            div_opa_o    = 32'h0;
            div_opb_o    = 32'h0;
        end
    end

    // MF read path: committed registers only, no bypass of same-cycle MT*
    always_comb begin
        mf_data_o = 32'h0;
        if (valid_i && !rst) begin
            if (op_i == EXE_MFHI_OP)      mf_data_o = hi_q;
            else if (op_i == EXE_MFLO_OP) mf_data_o = lo_q;
        end
    end

    // State and multiply countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // HI/LO commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= HILO_RST[63:32];
            lo_q <= HILO_RST[31:0];
        end else begin
            if (hi_we) hi_q <= hi_d;
            if (lo_we) lo_q <= lo_d;
        end
    end

    // Multiplier operand stage; product is formed from these while in MUL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q   <= 32'h0;
            mul_b_q   <= 32'h0;
            mul_sgn_q <= 1'b0;
        end else if (mul_ld) begin
            mul_a_q   <= a_i;
            mul_b_q   <= b_i;
            mul_sgn_q <= (op_i == EXE_MULT_OP);
        end
    end

    // Divider operand latches keep the handshake stable while EX changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_a_q   <= 32'h0;
            div_b_q   <= 32'h0;
            div_sgn_q <= 1'b0;
        end else if (div_ld) begin
            div_a_q   <= a_i;
            div_b_q   <= b_i;
            div_sgn_q <= (op_i == EXE_DIV_OP);
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a behavioural iterative divider.
module tb_hilo_muldiv_ctrl;

    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam int         DIV_LAT  = 34;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, flush_i;
    logic [7:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        stall_o;
    logic [31:0] mf_data_o, hi_o, lo_o;
    logic        div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_opa_o, div_opb_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    int          n_chk = 0;
    int          n_err = 0;
    int          mcnt;
    logic        m_ready, ready_force;

    hilo_muldiv_ctrl #(.MUL_STAGES(2), .HILO_RST(64'h0)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .stall_o(stall_o),
        .mf_data_o(mf_data_o), .hi_o(hi_o), .lo_o(lo_o),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_annul_o(div_annul_o), .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i)
    );

    always #5 clk = ~clk;

    // Divider model: ready after DIV_LAT edges with start held
    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= 0;
        else if (!div_start_o || div_annul_o) mcnt <= 0;
        else if (mcnt != DIV_LAT) mcnt <= mcnt + 1;
    end
    assign m_ready     = (mcnt == DIV_LAT) && div_start_o;
    assign div_ready_i = m_ready | ready_force;

    always_comb begin
        div_result_i = 64'h0;
        if (div_opb_o == 32'h0)
            div_result_i = {div_opa_o, 32'hFFFF_FFFF};
        else if (div_signed_o)
            div_result_i = {32'($signed(div_opa_o) % $signed(div_opb_o)),
                            32'($signed(div_opa_o) / $signed(div_opb_o))};
        else
            div_result_i = {div_opa_o % div_opb_o, div_opa_o / div_opb_o};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        valid_i = v;
        op_i    = op;
        a_i     = a;
        b_i     = b;
    endtask

    // Step through DIV_BUSY until ready; checks stall/start/operands held
    task automatic wait_ready(input logic [31:0] exp_a, output int waits);
        logic bad;
        bad   = 1'b0;
        waits = 0;
        while (!div_ready_i && waits < 60) begin
            if (stall_o !== 1'b1 || div_start_o !== 1'b1 || div_opa_o !== exp_a) bad = 1'b1;
            cyc();
            waits++;
        end
        chk("div_hold", {63'h0, bad}, 64'h0);
        chk("div_ready_seen", {63'h0, div_ready_i}, 64'h1);
    endtask

    int w;

    initial begin
        rst = 1'b1; flush_i = 1'b0; ready_force = 1'b0;
        drive(1'b0, 8'h0, 32'h0, 32'h0);
        #12;
        chk("rst_hi", {32'h0, hi_o}, 64'h0);
        chk("rst_lo", {32'h0, lo_o}, 64'h0);
        chk("rst_ctl", {60'h0, stall_o, div_start_o, div_annul_o, div_signed_o}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        // MTHI then MFHI
        drive(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        #1 chk("mthi_stall", {63'h0, stall_o}, 64'h0);
        cyc();
        drive(1'b1, OP_MFHI, 32'h0, 32'h0);
        #1 chk("mfhi", {32'h0, mf_data_o}, {32'h0, 32'hDEAD_BEEF});
        chk("mthi_lo", {32'h0, lo_o}, 64'h0);
        drive(1'b1, OP_MFLO, 32'h0, 32'h0);
        #1 chk("mflo", {32'h0, mf_data_o}, 64'h0);
        drive(1'b0, OP_MFHI, 32'h0, 32'h0);
        #1 chk("mf_bubble", {32'h0, mf_data_o}, 64'h0);
        cyc();

        // MULT -2 * 3
        drive(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
        #1 chk("mult_stall1", {63'h0, stall_o}, 64'h1);
        cyc();
        chk("mult_stall2", {63'h0, stall_o}, 64'h0);
        cyc();
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        drive(1'b1, OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        #1 chk("multu_stall1", {63'h0, stall_o}, 64'h1);
        cyc();
        chk("multu_stall2", {63'h0, stall_o}, 64'h0);
        cyc();
        chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

        // DIV -7 / 2 with changing EX operands
        drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        #1 chk("div_issue", {60'h0, stall_o, div_start_o, div_signed_o, div_annul_o}, 64'hE);
        chk("div_opa_issue", {32'h0, div_opa_o}, {32'h0, 32'hFFFF_FFF9});
        cyc();
        drive(1'b1, OP_DIV, 32'h1234_5678, 32'h0);
        #1;
        wait_ready(32'hFFFF_FFF9, w);
        chk("div_wait_cycles", 64'(w), 64'd33);
        chk("div_ready_stall", {63'h0, stall_o}, 64'h0);
        chk("div_opb_stable", {32'h0, div_opb_o}, 64'd2);
        cyc();
        chk("div_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        drive(1'b0, 8'h0, 32'h0, 32'h0);
        cyc();

        // DIVU 100/7 then DIVU 9/3 back to back
        drive(1'b1, OP_DIVU, 32'd100, 32'd7);
        #1 chk("divu1_start", {62'h0, div_start_o, div_signed_o}, 64'h2);
        cyc();
        wait_ready(32'd100, w);
        cyc();
        chk("divu1_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
        drive(1'b1, OP_DIVU, 32'd9, 32'd3);
        #1 chk("divu2_done_cyc", {62'h0, stall_o, div_start_o}, 64'h2);
        cyc();
        chk("divu2_idle_cyc", {62'h0, stall_o, div_start_o}, 64'h3);
        cyc();
        wait_ready(32'd9, w);
        cyc();
        chk("divu2_hilo", {hi_o, lo_o}, {32'd0, 32'd3});
        drive(1'b0, 8'h0, 32'h0, 32'h0);
        cyc();

        // flush in DIV_BUSY with same-cycle ready
        drive(1'b1, OP_DIV, 32'd20, 32'd5);
        cyc(); cyc(); cyc();
        flush_i = 1'b1; ready_force = 1'b1;
        #1 chk("flush_ctl", {61'h0, div_annul_o, div_start_o, stall_o}, 64'h4);
        cyc();
        flush_i = 1'b0; ready_force = 1'b0;
        drive(1'b0, 8'h0, 32'h0, 32'h0);
        #1 chk("flush_annul_pulse", {62'h0, div_annul_o, div_start_o}, 64'h0);
        chk("flush_hilo", {hi_o, lo_o}, {32'd0, 32'd3});
        drive(1'b1, OP_MTLO, 32'hAAAA_5555, 32'h0);
        cyc();
        chk("mtlo_after_flush", {hi_o, lo_o}, {32'd0, 32'hAAAA_5555});

        // reset while DIV_BUSY
        drive(1'b1, OP_DIVU, 32'd50, 32'd5);
        cyc(); cyc();
        chk("busy_before_rst", {62'h0, stall_o, div_start_o}, 64'h3);
        rst = 1'b1;
        #1 chk("rst_busy_ctl", {62'h0, stall_o, div_start_o}, 64'h0);
        chk("rst_busy_hilo", {hi_o, lo_o}, 64'h0);
        drive(1'b0, 8'h0, 32'h0, 32'h0);
        cyc();
        rst = 1'b0;
        #1 chk("post_rst_idle", {62'h0, stall_o, div_start_o}, 64'h0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
EX-stage controller that owns the HI/LO register pair and sequences all multiply, divide and HI/LO-move instructions. It drives an external iterative divider through a start/annul/ready handshake and runs a parameterised internal multiplier pipeline. It raises a pipeline stall while a multi-cycle operation is in flight and commits {HI,LO} exactly once per completed instruction. It serves MFHI/MFLO reads from the committed registers.

Parameters:
MUL_STAGES, 2, multiply latency in cycles (legal 1..4); stall_o is asserted for MUL_STAGES-1 cycles.
HILO_RST, 64'h0, reset value of {HI,LO}.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
valid_i  in  1  EX holds a real instruction (not a bubble)
flush_i  in  1  kill the EX instruction and any in-flight operation
op_i  in  8  EXE_*_OP encoding from defines.vh
a_i  in  32  rs operand
b_i  in  32  rt operand
stall_o  out  1  hold IF..EX
mf_data_o  out  32  HI for MFHI, LO for MFLO, else 0
hi_o  out  32  committed HI
lo_o  out  32  committed LO
div_start_o  out  1  divider start; held high until ready is seen
div_signed_o  out  1  1 = DIV, 0 = DIVU
div_annul_o  out  1  divider abort, one-cycle pulse
div_opa_o  out  32  dividend
div_opb_o  out  32  divisor
div_result_i  in  64  {remainder, quotient}
div_ready_i  in  1  divider result valid

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - {HI,LO}=HILO_RST.
  - All outputs 0 except hi_o/lo_o, which show HILO_RST.
- "go" = valid_i & ~flush_i. HI/LO is written only on a rising edge.
- States: IDLE, MUL, DIV_BUSY, DIV_DONE.
- IDLE, with go asserted:
  - MTHI: HI<=a_i. MTLO: LO<=a_i. No stall.
  - MULT/MULTU, MUL_STAGES=1: {HI,LO}<=64-bit product at the edge. MULT is signed×signed; MULTU is unsigned×unsigned. No stall.
  - MULT/MULTU, MUL_STAGES>1:
    - Latch a_i, b_i and signedness; cnt<=MUL_STAGES-1; go to MUL.
    - stall_o=1 combinationally in this cycle.
  - DIV/DIVU:
    - div_start_o=1 and stall_o=1 combinationally.
    - div_signed_o=(op==DIV). div_opa_o=a_i, div_opb_o=b_i.
    - Latch operands, op and sign; go to DIV_BUSY.
  - MFHI/MFLO and all other ops: no state change.
- MUL:
  - stall_o=1 while cnt>1.
  - When cnt==1: stall_o=0, {HI,LO}<=product of the latched operands; go to IDLE.
  - Otherwise cnt decrements each cycle.
- DIV_BUSY:
  - div_start_o=1; div_opa_o/div_opb_o/div_signed_o come from the latches, stable regardless of a_i/b_i/op_i.
  - stall_o=~div_ready_i.
  - On div_ready_i: HI<=div_result_i[63:32], LO<=div_result_i[31:0]; go to DIV_DONE.
- DIV_DONE (one cycle):
  - div_start_o=0, which returns the divider to free.
  - Behaves as IDLE for MT*/MULT*/MF*.
  - A DIV/DIVU arriving in this cycle gets stall_o=1, no start, and state goes to IDLE. It is issued there on the next cycle.
- flush_i:
  - In any state, no HI/LO write this cycle; stall_o=0; next state IDLE.
  - In DIV_BUSY: div_annul_o=1 and div_start_o=0 for that cycle.
  - flush_i wins over a same-cycle div_ready_i: result discarded.
- Divide by zero is not special-cased; whatever the divider returns is committed.
- mf_data_o is combinational from committed registers only, with no same-cycle bypass. An MFHI directly after MTHI (next cycle) reads the new value.
- valid_i=0 in IDLE: no action.

Test Plan:
- Reset mid-operation: rst asserted in DIV_BUSY -> next cycle stall_o=0, div_start_o=0, hi_o=lo_o=0, state IDLE.
- MTHI/MFHI: MTHI a=32'hDEADBEEF, then MFHI -> mf_data_o=32'hDEADBEEF one cycle later; lo_o unchanged.
- MULT with MUL_STAGES=2, a=32'hFFFFFFFE (-2), b=3:
  - stall_o high exactly 1 cycle.
  - HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
  - MULTU with the same operands: HI=2, LO=32'hFFFFFFFA.
- DIV with a=-7, b=2, model divider ready after 34 cycles:
  - stall_o high until the ready cycle; div_start_o held.
  - LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - Operands on div_op*_o stay stable while a_i changes.
- Back-to-back DIVU 100/7 then DIVU 9/3: second start only after the DIV_DONE and IDLE cycles; final HI=0, LO=3.
- flush_i during DIV_BUSY, with ready arriving the same cycle -> div_annul_o pulse, HI/LO unchanged, stall_o=0; the next MTLO commits normally.
